// File: rtl/phase_decoder.sv
// phase_decoder: samples the one-hot phase bus from the five-phase sequencer,
// encodes it to a binary index, and checks that phases arrive in order.
// An order check runs while tracking. Order and encoding faults set sticky
// flags. Completed instruction cycles are counted with a saturating counter.
module phase_decoder #(
  parameter int NPHASE = 5,
  parameter int IDXW   = 3,
  parameter int CNTW   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NPHASE-1:0] phase,
  input  logic              hold,
  input  logic              clear_err,
  output logic [IDXW-1:0]   phase_idx,
  output logic              phase_valid,
  output logic              last_phase,
  output logic              cycle_done,
  output logic [CNTW-1:0]   instr_count,
  output logic              err_onehot,
  output logic              err_seq
);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPHASE - 1);

  state_t          state, state_n;
  logic            is_onehot;
  logic [IDXW-1:0] enc_idx;
  logic [IDXW-1:0] expected;
  logic [IDXW-1:0] idx_n;
  logic            valid_n;
  logic            last_n;
  logic            done_n;
  logic [CNTW-1:0] cnt_n;
  logic            err_onehot_n;
  logic            err_seq_n;

  // Decode the phase bus: count set bits and encode the position of the set bit.
  always_comb begin
    int unsigned ones;
    ones    = 0;
    enc_idx = '0;
    for (int unsigned i = 0; i < NPHASE; i++) begin
      if (phase[i]) begin
        ones    = ones + 1;
        enc_idx = IDXW'(i);
      end
    end
    is_onehot = (ones == 1);
  end

  // The phase expected this cycle, relative to the last accepted index.
  always_comb begin
    if (hold) begin
      expected = phase_idx;
    end else if (phase_idx == LAST_IDX) begin
      expected = '0;
    end else begin
      expected = phase_idx + IDXW'(1);
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n      = state;
    idx_n        = phase_idx;
    valid_n      = phase_valid;
    last_n       = last_phase;
    done_n       = 1'b0;
    cnt_n        = instr_count;
    // A fresh error detected below overrides the clear.
    err_onehot_n = clear_err ? 1'b0 : err_onehot;
    err_seq_n    = clear_err ? 1'b0 : err_seq;

    case (state)
      SYNC: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        // Only a clean phase 0 starts tracking; anything else is silently ignored.
        if (is_onehot && (enc_idx == '0)) begin
          state_n = TRACK;
          idx_n   = '0;
          valid_n = 1'b1;
          last_n  = (LAST_IDX == '0);
        end
      end

      TRACK: begin
        if (!is_onehot) begin
          err_onehot_n = 1'b1;
          state_n      = SYNC;
          valid_n      = 1'b0;
          last_n       = 1'b0;
        end else if (enc_idx != expected) begin
          err_seq_n = 1'b1;
          state_n   = SYNC;
          valid_n   = 1'b0;
          last_n    = 1'b0;
        end else begin
          idx_n   = enc_idx;
          valid_n = 1'b1;
          last_n  = (enc_idx == LAST_IDX);
          // Accepted without hold after the last phase means a real wrap to 0.
          if (!hold && (phase_idx == LAST_IDX)) begin
            done_n = 1'b1;
            if (instr_count != '1) begin
              cnt_n = instr_count + CNTW'(1);
            end
          end
        end
      end

      default: begin
        state_n = SYNC;
        valid_n = 1'b0;
        last_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards all tracking immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      phase_idx   <= '0;
      phase_valid <= 1'b0;
      last_phase  <= 1'b0;
      cycle_done  <= 1'b0;
      instr_count <= '0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      state       <= state_n;
      phase_idx   <= idx_n;
      phase_valid <= valid_n;
      last_phase  <= last_n;
      cycle_done  <= done_n;
      instr_count <= cnt_n;
      err_onehot  <= err_onehot_n;
      err_seq     <= err_seq_n;
    end
  end

endmodule

// File: tb/tb_phase_decoder.sv
// Directed testbench for phase_decoder: default instance plus a CNTW=4
// instance sharing the same inputs for the saturation scenario.
module tb_phase_decoder;

  logic        clock;
  logic        reset;
  logic [4:0]  phase;
  logic        hold;
  logic        clear_err;

  logic [2:0]  phase_idx;
  logic        phase_valid, last_phase, cycle_done, err_onehot, err_seq;
  logic [15:0] instr_count;

  logic [2:0]  phase_idx_s;
  logic        phase_valid_s, last_phase_s, cycle_done_s, err_onehot_s, err_seq_s;
  logic [3:0]  instr_count_s;

  int tests;
  int fails;

  phase_decoder #(.NPHASE(5), .IDXW(3), .CNTW(16)) dut (
    .clock(clock), .reset(reset), .phase(phase), .hold(hold), .clear_err(clear_err),
    .phase_idx(phase_idx), .phase_valid(phase_valid), .last_phase(last_phase),
    .cycle_done(cycle_done), .instr_count(instr_count),
    .err_onehot(err_onehot), .err_seq(err_seq)
  );

  phase_decoder #(.NPHASE(5), .IDXW(3), .CNTW(4)) dut_sat (
    .clock(clock), .reset(reset), .phase(phase), .hold(hold), .clear_err(clear_err),
    .phase_idx(phase_idx_s), .phase_valid(phase_valid_s), .last_phase(last_phase_s),
    .cycle_done(cycle_done_s), .instr_count(instr_count_s),
    .err_onehot(err_onehot_s), .err_seq(err_seq_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [4:0] ph, input logic hd, input logic clr);
    phase     = ph;
    hold      = hd;
    clear_err = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    phase = 5'b00000; hold = 1'b0; clear_err = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; phase = '0; hold = 1'b0; clear_err = 1'b0;
    #1 reset = 1'b0;
    #11;
    tests++; if (phase_idx !== 3'd0) begin $display("FAIL reset_idx got=%0d exp=0", phase_idx); fails++; end
    tests++; if (phase_valid !== 1'b0) begin $display("FAIL reset_valid got=%0b exp=0", phase_valid); fails++; end
    tests++; if (instr_count !== 16'd0) begin $display("FAIL reset_count got=%0d exp=0", instr_count); fails++; end
    tests++; if ({last_phase, cycle_done, err_onehot, err_seq} !== 4'b0000) begin
      $display("FAIL reset_flags got=%b exp=0000", {last_phase, cycle_done, err_onehot, err_seq}); fails++; end
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Test 1: sync from zero, one full sequence, one wrap.
  task automatic test_sequence();
    logic [4:0] pv [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    logic [2:0] iv [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    step(5'b00000, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    tests++; if (phase_valid !== 1'b0) begin $display("FAIL seq_zero_valid got=%0b exp=0", phase_valid); fails++; end
    for (int k = 0; k < 6; k++) begin
      step(pv[k], 1'b0, 1'b0);
      tests++; if (phase_valid !== 1'b1 || phase_idx !== iv[k]) begin
        $display("FAIL seq_idx[%0d] got=%0d/%0b exp=%0d/1", k, phase_idx, phase_valid, iv[k]); fails++; end
      tests++; if (last_phase !== (k == 4)) begin
        $display("FAIL seq_last[%0d] got=%0b exp=%0b", k, last_phase, (k == 4)); fails++; end
      tests++; if (cycle_done !== (k == 5)) begin
        $display("FAIL seq_done[%0d] got=%0b exp=%0b", k, cycle_done, (k == 5)); fails++; end
    end
    tests++; if (instr_count !== 16'd1) begin $display("FAIL seq_count got=%0d exp=1", instr_count); fails++; end
    tests++; if (err_onehot !== 1'b0 || err_seq !== 1'b0) begin
      $display("FAIL seq_noerr got=%b%b exp=00", err_onehot, err_seq); fails++; end
  endtask

  // Test 2: hold repeats phase 2; release advances to 3.
  task automatic test_hold();
    step(5'b00010, 1'b0, 1'b0);
    step(5'b00100, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(5'b00100, 1'b1, 1'b0);
      tests++; if (phase_idx !== 3'd2 || phase_valid !== 1'b1) begin
        $display("FAIL hold_idx[%0d] got=%0d/%0b exp=2/1", k, phase_idx, phase_valid); fails++; end
    end
    tests++; if (err_onehot !== 1'b0 || err_seq !== 1'b0) begin
      $display("FAIL hold_noerr got=%b%b exp=00", err_onehot, err_seq); fails++; end
    step(5'b01000, 1'b0, 1'b0);
    tests++; if (phase_idx !== 3'd3) begin $display("FAIL hold_release got=%0d exp=3", phase_idx); fails++; end
    step(5'b10000, 1'b0, 1'b0);
    step(5'b00001, 1'b0, 1'b0);
    tests++; if (cycle_done !== 1'b1 || instr_count !== 16'd2) begin
      $display("FAIL hold_wrap got=%0b/%0d exp=1/2", cycle_done, instr_count); fails++; end
  endtask

  // Test 3: skipped phase sets err_seq, resync keeps flag until cleared.
  task automatic test_seq_err();
    step(5'b00010, 1'b0, 1'b0);
    step(5'b01000, 1'b0, 1'b0);
    tests++; if (err_seq !== 1'b1 || phase_valid !== 1'b0) begin
      $display("FAIL seqerr_set got=%0b/%0b exp=1/0", err_seq, phase_valid); fails++; end
    tests++; if (phase_idx !== 3'd1) begin $display("FAIL seqerr_idx_held got=%0d exp=1", phase_idx); fails++; end
    step(5'b00001, 1'b0, 1'b0);
    tests++; if (phase_valid !== 1'b1 || phase_idx !== 3'd0 || cycle_done !== 1'b0) begin
      $display("FAIL seqerr_resync got=%0b/%0d/%0b exp=1/0/0", phase_valid, phase_idx, cycle_done); fails++; end
    tests++; if (err_seq !== 1'b1) begin $display("FAIL seqerr_sticky got=%0b exp=1", err_seq); fails++; end
    step(5'b00010, 1'b0, 1'b1);
    tests++; if (err_seq !== 1'b0 || phase_idx !== 3'd1) begin
      $display("FAIL seqerr_clear got=%0b/%0d exp=0/1", err_seq, phase_idx); fails++; end
  endtask

  // Test 4: two-hot phase with simultaneous clear; error wins, then clears.
  task automatic test_onehot_err();
    step(5'b00110, 1'b0, 1'b1);
    tests++; if (err_onehot !== 1'b1 || phase_valid !== 1'b0) begin
      $display("FAIL onehot_set got=%0b/%0b exp=1/0", err_onehot, phase_valid); fails++; end
    step(5'b00000, 1'b0, 1'b1);
    tests++; if (err_onehot !== 1'b0) begin $display("FAIL onehot_clear got=%0b exp=0", err_onehot); fails++; end
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    tests++; if (err_onehot !== 1'b1 || err_seq !== 1'b0 || phase_valid !== 1'b0) begin
      $display("FAIL onehot_zero got=%0b/%0b/%0b exp=1/0/0", err_onehot, err_seq, phase_valid); fails++; end
    step(5'b00000, 1'b0, 1'b1);
  endtask

  // Hold on phase 0 after the last phase is an order error; hold in SYNC is ignored.
  task automatic test_hold_wrap();
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00010, 1'b0, 1'b0);
    step(5'b00100, 1'b0, 1'b0);
    step(5'b01000, 1'b0, 1'b0);
    step(5'b10000, 1'b0, 1'b0);
    step(5'b00001, 1'b1, 1'b0);
    tests++; if (err_seq !== 1'b1 || cycle_done !== 1'b0 || phase_idx !== 3'd4) begin
      $display("FAIL holdwrap_err got=%0b/%0b/%0d exp=1/0/4", err_seq, cycle_done, phase_idx); fails++; end
    tests++; if (last_phase !== 1'b0 || phase_valid !== 1'b0) begin
      $display("FAIL holdwrap_invalid got=%0b/%0b exp=0/0", last_phase, phase_valid); fails++; end
    step(5'b00001, 1'b1, 1'b0);
    tests++; if (phase_valid !== 1'b1 || phase_idx !== 3'd0 || cycle_done !== 1'b0) begin
      $display("FAIL holdwrap_sync got=%0b/%0d/%0b exp=1/0/0", phase_valid, phase_idx, cycle_done); fails++; end
    step(5'b00010, 1'b0, 1'b1);
  endtask

  // Test 5: 17 wraps; the 4-bit counter saturates at 15.
  task automatic test_saturate();
    logic [4:0] pv [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    do_reset();
    step(5'b00001, 1'b0, 1'b0);
    for (int c = 0; c < 17; c++) begin
      for (int k = 0; k < 5; k++) step(pv[k], 1'b0, 1'b0);
      if (c == 14) begin
        tests++; if (instr_count_s !== 4'd15) begin $display("FAIL sat_reach got=%0d exp=15", instr_count_s); fails++; end
      end
    end
    tests++; if (instr_count_s !== 4'd15 || cycle_done_s !== 1'b1) begin
      $display("FAIL sat_hold got=%0d/%0b exp=15/1", instr_count_s, cycle_done_s); fails++; end
    tests++; if (instr_count !== 16'd17) begin $display("FAIL sat_wide got=%0d exp=17", instr_count); fails++; end
  endtask

  // Test 6: asynchronous reset in the middle of phase 3.
  task automatic test_async_reset();
    step(5'b00010, 1'b0, 1'b0);
    step(5'b00100, 1'b0, 1'b0);
    step(5'b01000, 1'b0, 1'b0);
    tests++; if (phase_idx !== 3'd3) begin $display("FAIL arst_pre got=%0d exp=3", phase_idx); fails++; end
    #3 reset = 1'b0;
    #1;
    tests++; if ({phase_idx, phase_valid, last_phase, cycle_done, err_onehot, err_seq} !== 8'd0 || instr_count !== 16'd0) begin
      $display("FAIL arst_zero got=%0d/%0b/%0d exp=0/0/0", phase_idx, phase_valid, instr_count); fails++; end
    #2 reset = 1'b1;
    step(5'b00001, 1'b0, 1'b0);
    tests++; if (phase_valid !== 1'b1 || phase_idx !== 3'd0 || cycle_done !== 1'b0 || instr_count !== 16'd0) begin
      $display("FAIL arst_resync got=%0b/%0d/%0b/%0d exp=1/0/0/0", phase_valid, phase_idx, cycle_done, instr_count); fails++; end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sequence();
    test_hold();
    test_seq_err();
    test_onehot_err();
    test_hold_wrap();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
